// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and helpers for the encoder family
package encoder_pkg;

    typedef enum logic {
        ENC_MODE_FIXED = 1'b0,
        ENC_MODE_RR    = 1'b1
    } enc_mode_e;

    // Index width for an N-line encoder; never narrower than one bit.
    function automatic int enc_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_find.sv
// rtl/prio_find.sv - combinational downward set-bit search from a start index, wrapping 0 -> N-1
module prio_find
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = enc_width(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int s;
        int j;
        idx   = '0;
        found = 1'b0;
        // An out-of-range start can only arise for non-power-of-two N; treat it as the top line.
        s     = (int'(start) < N) ? int'(start) : N - 1;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = s - i;
            if (j < 0) begin
                j = j + N;
            end
            if (!found && vec[j]) begin
                found = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/priority_encoder_rr.sv
// rtl/priority_encoder_rr.sv - registered N-to-W encoder with fixed/round-robin priority and valid/ready output
module priority_encoder_rr
    import encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = enc_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic [W-1:0] code,
    output logic         out_valid,
    output logic         multi,
    output logic [W-1:0] ptr
);

    logic [W-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic         multi_q, multi_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [W-1:0] start;
    logic [W-1:0] win_idx;
    logic         found;
    logic         load;
    enc_mode_e    mode_sel;

    assign mode_sel = enc_mode_e'(mode);
    assign start    = (mode_sel == ENC_MODE_RR) ? ptr_q : W'(N - 1);
    assign load     = !valid_q || out_ready;

    prio_find #(.N(N)) u_find (
        .vec   (req),
        .start (start),
        .idx   (win_idx),
        .found (found)
    );

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        multi_d = multi_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (found) begin
                code_d  = win_idx;
                valid_d = 1'b1;
                // Clearing the lowest set bit leaves something only if two or more were set.
                multi_d = |(req & (req - N'(1)));
                if (mode_sel == ENC_MODE_RR) begin
                    ptr_d = (win_idx == '0) ? W'(N - 1) : win_idx - W'(1);
                end
            end else begin
                valid_d = 1'b0;
                multi_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            ptr_q   <= ptr_d;
        end
    end

    assign code      = code_q;
    assign out_valid = valid_q;
    assign multi     = multi_q;
    assign ptr       = ptr_q;

endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Parametrised, registered N-to-log2(N) encoder. It replaces the fixed 8-line one-hot octal-to-binary encoder.
- Adds selectable fixed-priority or round-robin resolution of multiple active lines.
- Adds a multi-hot flag and a valid/ready output handshake, so it can feed downstream pipelined logic directly.
- Sits between request sources and any consumer that needs a binary index.

## Interface
- N, default 8: number of request lines; legal range 2..256, not required to be a power of two.
- W: localparam, derived as max(1, $clog2(N)); not overridable.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  in  N  request lines, sampled only on a load cycle.
- out_ready  in  1  consumer accepts the current code.
- code  out  W  encoded index of the granted line.
- out_valid  out  1  code is valid.
- multi  out  1  more than one req bit was set when code was loaded.
- ptr  out  W  current round-robin start index (observability).

## Operation
- Output register is either EMPTY (out_valid=0) or FULL (out_valid=1).
- Load cycle: out_valid==0 || out_ready==1.
  - Load cycle with req!=0: code<=winner, multi<=(popcount(req)>1), out_valid<=1.
  - Load cycle with req==0: out_valid<=0, multi<=0. code holds its previous value.
- Non-load cycle (out_valid && !out_ready): code, multi and out_valid hold, and req is ignored.
- Winner search runs downward from a start index and wraps from 0 to N-1. The first set bit found wins.
  - mode=0: start = N-1, which gives pure highest-index priority.
  - mode=1: start = ptr.
- ptr update happens only on a load with req!=0 and mode=1: ptr <= (winner==0) ? N-1 : winner-1.
  - ptr holds in mode=0.
  - ptr never takes a value >= N.
- A mode change takes effect at the next load. ptr is preserved across mode changes.
- Single-bit req gives the same code in both modes, equal to the bit index (the octal encoder truth table when N=8).

## Timing
- Reset values: code=0, out_valid=0, multi=0, ptr=N-1. All clear immediately on rst_n falling, independent of clk.
- Reset asserted mid-stall drops the pending code; no handshake completes.
- First load is allowed on the first rising edge after rst_n deasserts.
- Latency: req sampled at edge k appears on code/out_valid after edge k. One cycle, full throughput with out_ready held high.
- All outputs come straight from flops. There is no combinational path from req, mode or out_ready to any output.
- A transfer completes on an edge where out_valid && out_ready. A new load may occur on that same edge (back-to-back).

## Structure
- Shared package encoder_pkg holds:
  - the mode enum (ENC_MODE_FIXED=0, ENC_MODE_RR=1);
  - a function computing W from N, reused by other encoder variants.
- One sub-module, prio_find #(N):
  - inputs: vec[N-1:0] and start[W-1:0];
  - outputs: idx[W-1:0] and found;
  - purely combinational, downward search with wrap.
- Top level holds the output register, handshake logic, popcount>1 detect and ptr register.

## Test plan
- One-hot sweep, N=8, out_ready=1, mode=0 then mode=1: req=1<<k for k=0..7 -> code=k one cycle later, out_valid=1, multi=0.
- Fixed priority, mode=0, req=8'hA6 held for 3 cycles -> code=7 each cycle, multi=1, ptr stays 7.
- Round-robin, mode=1, req=8'hFF, out_ready=1, from reset -> codes 7,6,5,4,3,2,1,0,7 (wrap), multi=1 throughout.
- Backpressure:
  - setup: load code=3, then out_ready=0 for 4 cycles while req switches to 8'h40 -> code stays 3 and out_valid stays 1;
  - raise out_ready -> code=6 after that edge.
- Empty: req=0 with out_ready=1 -> out_valid=0 and multi=0 one cycle later; code holds its last value.
- Async reset mid-stall, with out_valid=1 and code=5: pulse rst_n low between edges -> outputs and ptr reset as specified before the next edge; then mode=1, req=8'hFF -> first code=7.
